// File: rtl/arcade_input_mapper.sv
// Player-input front end: decodes ps2 key events into held-key state, merges with two
// joysticks, and drives registered per-player controls with autofire and a stretched coin pulse.
module arcade_input_mapper #(
    parameter int NBTN        = 6,
    parameter int COIN_CYCLES = 440000,
    parameter int AF_DIV      = 366667
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic [10:0]     ps2_key,
    input  logic [15:0]     joystick_0,
    input  logic [15:0]     joystick_1,
    input  logic            cocktail,
    input  logic            autofire_en,
    output logic [NBTN-1:0] p1_ctrl,
    output logic [NBTN-1:0] p2_ctrl,
    output logic [1:0]      start,
    output logic            coin
);

    localparam int CW   = $clog2(COIN_CYCLES + 1);
    localparam int AW   = $clog2(AF_DIV);
    localparam int NKEY = 19;

    localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_CYCLES);
    localparam logic [CW-1:0] COIN_ONE  = CW'(1);
    localparam logic [AW-1:0] AF_LAST   = AW'(AF_DIV - 1);
    localparam logic [AW-1:0] AF_ONE    = AW'(1);

    logic            old_toggle_q, old_toggle_d;
    logic [NKEY-1:0] keys_q, keys_d;
    logic [NBTN-1:0] p1_ctrl_q, p1_ctrl_d;
    logic [NBTN-1:0] p2_ctrl_q, p2_ctrl_d;
    logic [1:0]      start_q, start_d;
    logic            coin_q, coin_d;
    logic [CW-1:0]   ccnt_q, ccnt_d;
    logic            coin_raw_q, coin_raw_d;
    logic [1:0]      fire_raw_q, fire_raw_d;
    logic [1:0]      af_phase_q, af_phase_d;
    logic [AW-1:0]   af_cnt_q [2];
    logic [AW-1:0]   af_cnt_d [2];

    logic            key_event;
    logic            key_hit;
    logic [4:0]      key_sel;
    logic [NBTN-1:0] kp1, kp2, p1_raw, p2_raw;
    logic [1:0]      start_raw;
    logic            coin_raw;
    logic [1:0]      fire_out;

    assign key_event    = ps2_key[10] != old_toggle_q;
    assign old_toggle_d = ps2_key[10];

    // One state bit per listed key, so two keys sharing a function release independently.
    always_comb begin
        key_hit = 1'b1;
        key_sel = 5'd0;
        case (ps2_key[8:0])
            9'h175:  key_sel = 5'd0;
            9'h172:  key_sel = 5'd1;
            9'h16B:  key_sel = 5'd2;
            9'h174:  key_sel = 5'd3;
            9'h029:  key_sel = 5'd4;
            9'h014:  key_sel = 5'd5;
            9'h114:  key_sel = 5'd6;
            9'h02D:  key_sel = 5'd7;
            9'h02B:  key_sel = 5'd8;
            9'h023:  key_sel = 5'd9;
            9'h034:  key_sel = 5'd10;
            9'h01C:  key_sel = 5'd11;
            9'h01B:  key_sel = 5'd12;
            9'h005:  key_sel = 5'd13;
            9'h016:  key_sel = 5'd14;
            9'h006:  key_sel = 5'd15;
            9'h01E:  key_sel = 5'd16;
            9'h02E:  key_sel = 5'd17;
            9'h036:  key_sel = 5'd18;
            default: key_hit = 1'b0;
        endcase
    end

    always_comb begin
        keys_d = keys_q;
        if (key_event && key_hit) begin
            keys_d[key_sel] = ps2_key[9];
        end
    end

    // Merge uses keys_d so a key event reaches the output register in the same cycle.
    always_comb begin
        kp1      = '0;
        kp2      = '0;
        kp1[5:0] = {keys_d[5] | keys_d[6], keys_d[4], keys_d[0], keys_d[1], keys_d[2], keys_d[3]};
        kp2[5:0] = {keys_d[12], keys_d[11], keys_d[7], keys_d[8], keys_d[9], keys_d[10]};
        if (cocktail) begin
            p1_raw = kp1 | joystick_0[NBTN-1:0];
            p2_raw = kp2 | joystick_1[NBTN-1:0];
        end else begin
            p1_raw = kp1 | kp2 | joystick_0[NBTN-1:0] | joystick_1[NBTN-1:0];
            p2_raw = p1_raw;
        end
        start_raw[0] = keys_d[13] | keys_d[14] | joystick_0[NBTN]   | joystick_1[NBTN];
        start_raw[1] = keys_d[15] | keys_d[16] | joystick_0[NBTN+1] | joystick_1[NBTN+1];
        coin_raw     = keys_d[17] | keys_d[18] | joystick_0[NBTN+2] | joystick_1[NBTN+2];
    end

    assign fire_raw_d = {p2_raw[4], p1_raw[4]};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            af_cnt_d[i]   = '0;
            af_phase_d[i] = 1'b0;
            if (autofire_en && fire_raw_d[i]) begin
                if (!fire_raw_q[i]) begin
                    af_phase_d[i] = 1'b1;
                end else if (af_cnt_q[i] == AF_LAST) begin
                    af_phase_d[i] = ~af_phase_q[i];
                end else begin
                    af_cnt_d[i]   = af_cnt_q[i] + AF_ONE;
                    af_phase_d[i] = af_phase_q[i];
                end
            end
            fire_out[i] = autofire_en ? af_phase_d[i] : fire_raw_d[i];
        end
    end

    assign coin_raw_d = coin_raw;

    always_comb begin
        ccnt_d = ccnt_q;
        if (coin_raw && !coin_raw_q) begin
            ccnt_d = COIN_LOAD;
        end else if (ccnt_q != '0) begin
            ccnt_d = ccnt_q - COIN_ONE;
        end
        coin_d = (ccnt_d != '0) | coin_raw;
    end

    always_comb begin
        p1_ctrl_d    = p1_raw;
        p2_ctrl_d    = p2_raw;
        p1_ctrl_d[4] = fire_out[0];
        p2_ctrl_d[4] = fire_out[1];
        start_d      = start_raw;
    end

    always_ff @(posedge clk_sys) begin
        old_toggle_q <= old_toggle_d;
        if (reset) begin
            keys_q      <= '0;
            p1_ctrl_q   <= '0;
            p2_ctrl_q   <= '0;
            start_q     <= '0;
            coin_q      <= 1'b0;
            ccnt_q      <= '0;
            coin_raw_q  <= 1'b0;
            fire_raw_q  <= '0;
            af_phase_q  <= '0;
            af_cnt_q[0] <= '0;
            af_cnt_q[1] <= '0;
        end else begin
            keys_q      <= keys_d;
            p1_ctrl_q   <= p1_ctrl_d;
            p2_ctrl_q   <= p2_ctrl_d;
            start_q     <= start_d;
            coin_q      <= coin_d;
            ccnt_q      <= ccnt_d;
            coin_raw_q  <= coin_raw_d;
            fire_raw_q  <= fire_raw_d;
            af_phase_q  <= af_phase_d;
            af_cnt_q[0] <= af_cnt_d[0];
            af_cnt_q[1] <= af_cnt_d[1];
        end
    end

    assign p1_ctrl = p1_ctrl_q;
    assign p2_ctrl = p2_ctrl_q;
    assign start   = start_q;
    assign coin    = coin_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper: directed scenarios plus random key/joystick traffic checked
// every cycle against a held-key / elapsed-time reference model.
module tb_arcade_input_mapper;

    localparam int NBTN        = 8;
    localparam int COIN_CYCLES = 5;
    localparam int AF_DIV      = 4;

    logic            clk_sys = 1'b0;
    logic            reset;
    logic [10:0]     ps2_key;
    logic [15:0]     joystick_0, joystick_1;
    logic            cocktail, autofire_en;
    logic [NBTN-1:0] p1_ctrl, p2_ctrl;
    logic [1:0]      start;
    logic            coin;

    arcade_input_mapper #(
        .NBTN(NBTN), .COIN_CYCLES(COIN_CYCLES), .AF_DIV(AF_DIV)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key),
        .joystick_0(joystick_0), .joystick_1(joystick_1),
        .cocktail(cocktail), .autofire_en(autofire_en),
        .p1_ctrl(p1_ctrl), .p2_ctrl(p2_ctrl), .start(start), .coin(coin)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: held[] indexed by {ext,code}; autofire as elapsed time since the
    // autofire run started; coin as the last cycle number the pulse must cover.
    bit              held [512];
    bit              m_tog;
    bit  [1:0]       m_fprev;
    bit              m_run [2];
    bit              m_base [2];
    int              m_t [2];
    bit              m_cprev;
    int              m_cyc = 0;
    int              m_cuntil = -1;
    bit [NBTN-1:0]   e_p1, e_p2;
    bit [1:0]        e_start;
    bit              e_coin;

    function automatic bit hk(input bit ext, input int code);
        return held[{ext, 8'(code)}];
    endfunction

    task automatic model_step();
        bit [5:0]      kp1, kp2;
        bit [NBTN-1:0] k1w, k2w, j0, j1, r1, r2;
        bit            raw_coin, raw, fout;
        if (reset) begin
            foreach (held[i]) held[i] = 1'b0;
            m_tog    = ps2_key[10];
            m_fprev  = '0;
            m_run    = '{1'b0, 1'b0};
            m_cprev  = 1'b0;
            m_cuntil = -1;
            e_p1 = '0; e_p2 = '0; e_start = '0; e_coin = 1'b0;
            m_cyc++;
            return;
        end
        if (ps2_key[10] != m_tog) begin
            held[ps2_key[8:0]] = ps2_key[9];
            m_tog = ps2_key[10];
        end
        kp1[0] = hk(1, 'h74); kp1[1] = hk(1, 'h6B); kp1[2] = hk(1, 'h72); kp1[3] = hk(1, 'h75);
        kp1[4] = hk(0, 'h29); kp1[5] = hk(0, 'h14) | hk(1, 'h14);
        kp2[0] = hk(0, 'h34); kp2[1] = hk(0, 'h23); kp2[2] = hk(0, 'h2B); kp2[3] = hk(0, 'h2D);
        kp2[4] = hk(0, 'h1C); kp2[5] = hk(0, 'h1B);
        k1w = NBTN'(kp1);
        k2w = NBTN'(kp2);
        j0  = joystick_0[NBTN-1:0];
        j1  = joystick_1[NBTN-1:0];
        if (cocktail) begin
            r1 = k1w | j0;
            r2 = k2w | j1;
        end else begin
            r1 = k1w | k2w | j0 | j1;
            r2 = r1;
        end
        e_start[0] = hk(0, 'h05) | hk(0, 'h16) | joystick_0[NBTN]   | joystick_1[NBTN];
        e_start[1] = hk(0, 'h06) | hk(0, 'h1E) | joystick_0[NBTN+1] | joystick_1[NBTN+1];
        raw_coin   = hk(0, 'h2E) | hk(0, 'h36) | joystick_0[NBTN+2] | joystick_1[NBTN+2];
        if (raw_coin && !m_cprev) m_cuntil = m_cyc + COIN_CYCLES - 1;
        e_coin  = raw_coin || (m_cyc <= m_cuntil);
        m_cprev = raw_coin;
        for (int p = 0; p < 2; p++) begin
            raw = (p == 0) ? r1[4] : r2[4];
            if (!raw) begin
                fout = 1'b0; m_run[p] = 1'b0;
            end else if (!autofire_en) begin
                fout = 1'b1; m_run[p] = 1'b0;
            end else begin
                if (!m_fprev[p]) begin
                    m_run[p] = 1'b1; m_base[p] = 1'b1; m_t[p] = 0;
                end else if (!m_run[p]) begin
                    m_run[p] = 1'b1; m_base[p] = 1'b0; m_t[p] = 1;
                end else begin
                    m_t[p]++;
                end
                fout = m_base[p] ^ bit'((m_t[p] / AF_DIV) % 2);
            end
            m_fprev[p] = raw;
            if (p == 0) begin r1[4] = fout; end else begin r2[4] = fout; end
        end
        e_p1 = r1;
        e_p2 = r2;
        m_cyc++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_sys);
        #1;
        check("p1_ctrl", 32'(p1_ctrl), 32'(e_p1));
        check("p2_ctrl", 32'(p2_ctrl), 32'(e_p2));
        check("start",   32'(start),   32'(e_start));
        check("coin",    32'(coin),    32'(e_coin));
    endtask

    task automatic key(input bit pressed, input logic [8:0] ec);
        ps2_key = {~ps2_key[10], pressed, ec};
    endtask

    logic [8:0]  pool [22] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h029, 9'h014, 9'h114, 9'h02D,
                               9'h02B, 9'h023, 9'h034, 9'h01C, 9'h01B, 9'h005, 9'h016, 9'h006,
                               9'h01E, 9'h02E, 9'h036, 9'h075, 9'h129, 9'h0AA};
    logic [19:0] af_pat = 20'b1111_0000_1111_0000_1111;
    int          cnt;

    initial begin
        reset = 1'b1; ps2_key = '0; joystick_0 = '0; joystick_1 = '0;
        cocktail = 1'b0; autofire_en = 1'b0;
        tick();

        // reset with a toggle mismatch pending
        ps2_key = {1'b1, 1'b1, 9'h175};
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_quiet", {p1_ctrl, p2_ctrl, start, coin}, 32'd0);
        end

        key(1'b1, 9'h175); tick(); check("key_up_press", 32'(p1_ctrl[3]), 32'd1);
        key(1'b0, 9'h175); tick(); check("key_up_release", 32'(p1_ctrl[3]), 32'd0);
        key(1'b1, 9'h075); tick(); check("unlisted_code", 32'(p1_ctrl), 32'd0);
        key(1'b0, 9'h075); tick();

        joystick_1[4] = 1'b1; tick();
        check("shared_p1_fire", 32'(p1_ctrl[4]), 32'd1);
        check("shared_p2_fire", 32'(p2_ctrl[4]), 32'd1);
        joystick_1 = '0; cocktail = 1'b1;
        key(1'b1, 9'h01C); tick();
        check("split_p1_fire", 32'(p1_ctrl[4]), 32'd0);
        check("split_p2_fire", 32'(p2_ctrl[4]), 32'd1);
        key(1'b0, 9'h01C); tick();

        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (k == 0) key(1'b1, 9'h02E);
            if (k == 1) key(1'b0, 9'h02E);
            tick();
            cnt += int'(coin);
        end
        check("coin_tap_len", 32'(cnt), 32'd5);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            if (k == 0 || k == 3) key(1'b1, 9'h02E);
            if (k == 1 || k == 4) key(1'b0, 9'h02E);
            tick();
            cnt += int'(coin);
        end
        check("coin_retap_len", 32'(cnt), 32'd8);

        autofire_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) key(1'b1, 9'h029);
            tick();
            check("af_shot", 32'(p1_ctrl[4]), 32'(af_pat[19-i]));
        end
        key(1'b0, 9'h029); tick();
        check("af_release", 32'(p1_ctrl[4]), 32'd0);
        autofire_en = 1'b0;

        joystick_0 = 16'h0100; tick(); check("joy_start1", 32'(start[0]), 32'd1);
        joystick_0 = 16'h0040; tick(); check("joy_extra6", 32'(p1_ctrl[6]), 32'd1);
        joystick_0 = 16'h0400; tick(); check("joy_coin", 32'(coin), 32'd1);
        joystick_0 = '0;       tick(); check("coin_stretch", 32'(coin), 32'd1);
        reset = 1'b1;          tick(); check("coin_reset", 32'(coin), 32'd0);
        reset = 1'b0;          tick();

        for (int it = 0; it < 3000; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 30) key(1'($urandom_range(0, 1)), pool[$urandom_range(0, 21)]);
            if ($urandom_range(0, 9) == 0) joystick_0 = joystick_0 ^ (16'h1 << $urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) joystick_1 = joystick_1 ^ (16'h1 << $urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) cocktail = ~cocktail;
            if ($urandom_range(0, 29) == 0) autofire_en = ~autofire_en;
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
